axi4l_regfile: RTL



---
 rtl/axi4l_pkg.sv | 16 +
 rtl/axi4l_regfile_if.sv | 37 +++
 rtl/axi4l_addr_decode.sv | 38 +++
 rtl/axi4l_regfile.sv | 123 ++++++++++++
 4 files changed

// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite definitions: response codes and address-geometry helpers.
package axi4l_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Number of address bits that select a byte inside one data word.
  function automatic int lane_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int sel_bits(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/axi4l_regfile_if.sv
// AXI4-Lite bus bundle between the interconnect (master) and the register file (slave).
interface axi4l_regfile_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   AWADDR;
  logic [2:0]          AWPROT;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic [2:0]          ARPROT;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID;
  logic                RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
           ARADDR, ARPROT, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
           ARADDR, ARPROT, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi4l_addr_decode.sv
// Combinational address decode: register select plus in-range and writable flags.
module axi4l_addr_decode
  import axi4l_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 32,
  parameter int                NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter int                SEL_W    = sel_bits(NUM_REGS)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [SEL_W-1:0]  sel,
  output logic              in_range,
  output logic              writable
);
  localparam int LB    = lane_bits(DATA_W);
  localparam int IDX_W = ADDR_W - LB;

  logic [IDX_W-1:0] idx;
  logic             ro;
  logic             unused_lsb;

  assign idx        = addr[ADDR_W-1:LB];
  assign sel        = idx[SEL_W-1:0];
  assign in_range   = 32'(idx) < NUM_REGS;
  assign unused_lsb = ^addr[LB-1:0];

  // Full-width compare keeps out-of-range indices from aliasing onto a mask bit.
  always_comb begin
    ro = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(idx) == i) ro = RO_MASK[i];
    end
  end

  assign writable = in_range && !ro;

endmodule

// File: rtl/axi4l_regfile.sv
// Parametrised AXI4-Lite slave register file with byte strobes, RO mapping and SLVERR decode.
module axi4l_regfile
  import axi4l_pkg::*;
#(
  parameter int                  ADDR_W   = 8,
  parameter int                  DATA_W   = 32,
  parameter int                  NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  axi4l_regfile_if.slave             s_axi,
  output logic [NUM_REGS*DATA_W-1:0] reg_out,
  input  logic [NUM_REGS*DATA_W-1:0] reg_in,
  output logic [NUM_REGS-1:0]        wr_pulse,
  output logic [NUM_REGS-1:0]        rd_pulse
);
  localparam int SEL_W = sel_bits(NUM_REGS);

  logic [DATA_W-1:0]   regs   [NUM_REGS];
  logic [DATA_W-1:0]   ro_vals[NUM_REGS];
  logic                ready_q;
  logic                aw_full, w_full;
  logic [ADDR_W-1:0]   awaddr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [SEL_W-1:0]    wsel, rsel;
  logic                wr_ok, rd_in_range, rd_writable;
  logic                unused_wr_in_range, unused_prot;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_lane
    assign reg_out[g*DATA_W +: DATA_W] = regs[g];
    assign ro_vals[g]                  = reg_in[g*DATA_W +: DATA_W];
  end

  assign unused_prot = ^{s_axi.AWPROT, s_axi.ARPROT};

  axi4l_addr_decode #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .RO_MASK(RO_MASK), .SEL_W(SEL_W)
  ) u_wr_dec (
    .addr(awaddr_q), .sel(wsel), .in_range(unused_wr_in_range), .writable(wr_ok)
  );

  axi4l_addr_decode #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .RO_MASK(RO_MASK), .SEL_W(SEL_W)
  ) u_rd_dec (
    .addr(s_axi.ARADDR), .sel(rsel), .in_range(rd_in_range), .writable(rd_writable)
  );

  // Holds all READY outputs low through reset and for the reset-release edge.
  always_ff @(posedge ACLK) ready_q <= !ARESET;

  assign s_axi.AWREADY = ready_q && !aw_full && !s_axi.BVALID;
  assign s_axi.WREADY  = ready_q && !w_full && !s_axi.BVALID;
  assign s_axi.ARREADY = ready_q && !s_axi.RVALID;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_full      <= 1'b0;
      w_full       <= 1'b0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      s_axi.BVALID <= 1'b0;
      s_axi.BRESP  <= RESP_OKAY;
      wr_pulse     <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_pulse <= '0;
      if (s_axi.AWVALID && s_axi.AWREADY) begin
        aw_full  <= 1'b1;
        awaddr_q <= s_axi.AWADDR;
      end
      if (s_axi.WVALID && s_axi.WREADY) begin
        w_full  <= 1'b1;
        wdata_q <= s_axi.WDATA;
        wstrb_q <= s_axi.WSTRB;
      end
      if (aw_full && w_full) begin
        aw_full      <= 1'b0;
        w_full       <= 1'b0;
        s_axi.BVALID <= 1'b1;
        if (wr_ok) begin
          for (int b = 0; b < DATA_W/8; b++) begin
            if (wstrb_q[b]) regs[wsel][b*8 +: 8] <= wdata_q[b*8 +: 8];
          end
          wr_pulse[wsel] <= 1'b1;
          s_axi.BRESP    <= RESP_OKAY;
        end else begin
          s_axi.BRESP <= RESP_SLVERR;
        end
      end else if (s_axi.BVALID && s_axi.BREADY) begin
        s_axi.BVALID <= 1'b0;
      end
    end
  end

  // Sampling regs on the commit edge returns the pre-write value on a collision.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      s_axi.RVALID <= 1'b0;
      s_axi.RDATA  <= '0;
      s_axi.RRESP  <= RESP_OKAY;
      rd_pulse     <= '0;
    end else begin
      rd_pulse <= '0;
      if (s_axi.ARVALID && s_axi.ARREADY) begin
        s_axi.RVALID <= 1'b1;
        if (rd_in_range) begin
          s_axi.RDATA    <= rd_writable ? regs[rsel] : ro_vals[rsel];
          s_axi.RRESP    <= RESP_OKAY;
          rd_pulse[rsel] <= 1'b1;
        end else begin
          s_axi.RDATA <= '0;
          s_axi.RRESP <= RESP_SLVERR;
        end
      end else if (s_axi.RVALID && s_axi.RREADY) begin
        s_axi.RVALID <= 1'b0;
      end
    end
  end

endmodule
